fifo_stream_drain: RTL and testbench

- Avalon-MM master that sits directly downstream of the FIFO wrapper's Avalon slave port.
- Polls the FIFO status, pops one word at a time through the data register and presents each word on a valid/ready stream to the next stage.
- Groups words into bursts of BURST_LEN and marks the final word of each burst with out_last.
- Keeps a free-running count of words it has delivered.

---
 rtl/fifo_stream_drain.sv | 119 +++++++++++
 tb/tb_fifo_stream_drain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a FIFO over Avalon-MM one word at a time and streams it out in bursts.
// Optional stall watchdog: define DRAIN_WATCHDOG_EN.
module fifo_stream_drain #(
    parameter int WIDTH        = 8,
    parameter int BURST_LEN    = 4,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drain_en,
    output logic [1:0]       avalon_address,
    output logic             avalon_read,
    output logic             avalon_write,
    output logic [WIDTH-1:0] avalon_writedata,
    input  logic [WIDTH-1:0] avalon_readdata,
    input  logic [1:0]       avalon_status,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [15:0]      word_count,
    output logic             stall_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t           state_q;
    logic [1:0]       lat_q;
    logic [7:0]       idx_q;
    logic             read_q;
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] data_q;
    logic [15:0]      count_q;
    logic             go;
    logic             unused_full;

    // full is deliberately ignored; empty is the only status that gates pops
    assign unused_full = avalon_status[1];
    assign go          = drain_en && !avalon_status[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lat_q   <= 2'd0;
            idx_q   <= 8'd0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            count_q <= 16'd0;
        end else begin
            read_q <= 1'b0;
            case (state_q)
                IDLE: if (go) begin
                    state_q <= REQ;
                    read_q  <= 1'b1;
                end
                REQ: begin
                    state_q <= WAIT;
                    lat_q   <= 2'(READ_LATENCY - 1);
                end
                WAIT: if (lat_q == 2'd0) begin
                    data_q  <= avalon_readdata;
                    valid_q <= 1'b1;
                    last_q  <= idx_q == 8'(BURST_LEN - 1);
                    state_q <= HOLD;
                end else begin
                    lat_q <= lat_q - 2'd1;
                end
                HOLD: if (out_ready) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    count_q <= count_q + 16'd1;
                    idx_q   <= (idx_q == 8'(BURST_LEN - 1)) ? 8'd0 : idx_q + 8'd1;
                    state_q <= go ? REQ : IDLE;
                    read_q  <= go;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign avalon_address   = 2'b00;
    assign avalon_read      = read_q;
    assign avalon_write     = 1'b0;
    assign avalon_writedata = '0;
    assign out_data         = data_q;
    assign out_valid        = valid_q;
    assign out_last         = last_q;
    assign word_count       = count_q;

`ifdef DRAIN_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          stall_q;

    // saturates at TIMEOUT so the counter cannot wrap back under the threshold
    always_comb
        wd_d = (valid_q && out_ready) ? '0 :
               (valid_q && wd_q != WW'(TIMEOUT)) ? wd_q + WW'(1) : wd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stall_q <= stall_q | (wd_d == WW'(TIMEOUT));
        end
    end

    assign stall_err = stall_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign stall_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed, table-driven checks of fifo_stream_drain against behavioural FIFO models.
module tb_fifo_stream_drain;
`ifdef DRAIN_WATCHDOG_EN
    localparam logic EXP_STALL = 1'b1;
`else
    localparam logic EXP_STALL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: READ_LATENCY=1, BURST_LEN=4
    logic       drain_en_a, out_ready_a, avalon_read_a, avalon_write_a, out_valid_a, out_last_a, stall_err_a;
    logic [1:0] avalon_address_a, status_a;
    logic [7:0] avalon_writedata_a, readdata_a, out_data_a;
    logic [15:0] word_count_a;

    // DUT B: READ_LATENCY=3, BURST_LEN=1
    logic       drain_en_b, out_ready_b, avalon_read_b, avalon_write_b, out_valid_b, out_last_b, stall_err_b;
    logic [1:0] avalon_address_b, status_b;
    logic [7:0] avalon_writedata_b, readdata_b, out_data_b;
    logic [15:0] word_count_b;

    fifo_stream_drain #(.WIDTH(8), .BURST_LEN(4), .READ_LATENCY(1), .TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset), .drain_en(drain_en_a),
        .avalon_address(avalon_address_a), .avalon_read(avalon_read_a),
        .avalon_write(avalon_write_a), .avalon_writedata(avalon_writedata_a),
        .avalon_readdata(readdata_a), .avalon_status(status_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a),
        .out_ready(out_ready_a), .word_count(word_count_a), .stall_err(stall_err_a)
    );

    fifo_stream_drain #(.WIDTH(8), .BURST_LEN(1), .READ_LATENCY(3), .TIMEOUT(64)) dut_b (
        .clk(clk), .reset(reset), .drain_en(drain_en_b),
        .avalon_address(avalon_address_b), .avalon_read(avalon_read_b),
        .avalon_write(avalon_write_b), .avalon_writedata(avalon_writedata_b),
        .avalon_readdata(readdata_b), .avalon_status(status_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b),
        .out_ready(out_ready_b), .word_count(word_count_b), .stall_err(stall_err_b)
    );

    // FIFO models: readdata shows the popped word only in its valid cycle, 0xEE otherwise
    logic [7:0] mem_a [0:31];
    logic [7:0] mem_b [0:31];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, reads_a = 0, reads_b = 0;
    logic       v1_a = 1'b0, v1_b = 1'b0, v2_b = 1'b0, v3_b = 1'b0;
    logic [7:0] d1_a = 8'h00, d1_b = 8'h00, d2_b = 8'h00, d3_b = 8'h00;

    assign status_a   = {1'b0, wr_a == rd_a};
    assign status_b   = {1'b0, wr_b == rd_b};
    assign readdata_a = v1_a ? d1_a : 8'hEE;
    assign readdata_b = v3_b ? d3_b : 8'hEE;

    always @(posedge clk) begin
        v1_a <= avalon_read_a && (wr_a != rd_a);
        if (avalon_read_a) reads_a <= reads_a + 1;
        if (avalon_read_a && wr_a != rd_a) begin
            d1_a <= mem_a[rd_a];
            rd_a <= rd_a + 1;
        end
        v1_b <= avalon_read_b && (wr_b != rd_b);
        v2_b <= v1_b;
        v3_b <= v2_b;
        d2_b <= d1_b;
        d3_b <= d2_b;
        if (avalon_read_b) reads_b <= reads_b + 1;
        if (avalon_read_b && wr_b != rd_b) begin
            d1_b <= mem_b[rd_b];
            rd_b <= rd_b + 1;
        end
    end

    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a] = v;
        wr_a = wr_a + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expired(input string name);
        total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Call at a sampling point; returns one negedge after the handshake edge.
    task automatic wait_hs(input string name, output logic [7:0] d, output logic l, output int c);
        int n = 0;
        while (!(out_valid_a && out_ready_a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) expired(name);
        d = out_data_a;
        l = out_last_a;
        c = cyc;
        @(negedge clk);
    endtask

    task automatic wait_valid_a(input string name);
        int n = 0;
        while (!out_valid_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) expired(name);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       l;
        int         c, prev, r0, tr, tv, n;
        tbl[0] = '{8'h11, 1'b0, 16'd0};
        tbl[1] = '{8'h22, 1'b0, 16'd1};
        tbl[2] = '{8'h33, 1'b0, 16'd2};
        tbl[3] = '{8'h44, 1'b1, 16'd3};
        tbl[4] = '{8'h55, 1'b0, 16'd4};
        reset = 1'b0;
        drain_en_a = 1'b0; out_ready_a = 1'b0;
        drain_en_b = 1'b0; out_ready_b = 1'b1;
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        repeat (3) @(negedge clk);
        chk("rst_read", avalon_read_a, 0);
        chk("rst_addr", avalon_address_a, 0);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_last", out_last_a, 0);
        chk("rst_data", out_data_a, 0);
        chk("rst_count", word_count_a, 0);
        chk("rst_stall", stall_err_a, 0);
        chk("rst_write", {avalon_write_a, avalon_writedata_a}, 0);
        chk("rst_b_valid", out_valid_b, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_reads", reads_a, 0);
        chk("idle_valid", out_valid_a, 0);
        chk("idle_count", word_count_a, 0);
        // Stream five words with out_ready high
        push_a(8'h44); push_a(8'h55);
        drain_en_a = 1'b1; out_ready_a = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            chk("drain_count_pre", word_count_a, tbl[i].cnt);
            wait_hs("drain_hs", d, l, c);
            chk("drain_data", d, tbl[i].data);
            chk("drain_last", l, tbl[i].last);
            if (i > 0) chk("drain_spacing", c - prev, 3);
            prev = c;
        end
        repeat (5) @(negedge clk);
        chk("drain_count", word_count_a, 5);
        chk("drain_reads", reads_a, 5);
        chk("drain_parked_valid", out_valid_a, 0);
        chk("drain_parked_read", avalon_read_a, 0);
        // Backpressure: hold 0xA5 for 10 cycles while another word waits in the FIFO
        out_ready_a = 1'b0;
        push_a(8'hA5);
        wait_valid_a("stall_valid");
        r0 = reads_a;
        push_a(8'hC3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_data", out_data_a, 8'hA5);
            chk("stall_last", out_last_a, 0);
        end
        chk("stall_no_read", reads_a, r0);
        out_ready_a = 1'b1;
        wait_hs("stall_hs", d, l, c);
        chk("stall_xfer", d, 8'hA5);
        wait_hs("c3_hs", d, l, c);
        chk("c3_data", d, 8'hC3);
        chk("c3_last", l, 0);
        push_a(8'hD4);
        wait_hs("d4_hs", d, l, c);
        chk("d4_data", d, 8'hD4);
        chk("d4_last", l, 1);
        // Advance burst index to 3, then reset in the WAIT of the next pop
        push_a(8'hE1); push_a(8'hE2); push_a(8'hE3);
        for (int i = 0; i < 3; i++) begin
            wait_hs("e_hs", d, l, c);
            chk("e_last", l, 0);
        end
        chk("pre_rst_count", word_count_a, 11);
        push_a(8'hF0);
        n = 0;
        while (!avalon_read_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) expired("f0_read");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_count", word_count_a, 0);
        chk("async_data", out_data_a, 0);
        chk("async_valid", out_valid_a, 0);
        chk("async_last", out_last_a, 0);
        chk("async_read", avalon_read_a, 0);
        @(negedge clk);
        reset = 1'b1;
        push_a(8'h5A);
        wait_hs("post_rst_hs", d, l, c);
        chk("post_rst_data", d, 8'h5A);
        chk("post_rst_last", l, 0);
        chk("post_rst_count", word_count_a, 1);
        // Watchdog: 64 stalled cycles
        out_ready_a = 1'b0;
        push_a(8'h66);
        wait_valid_a("wd_valid");
        repeat (63) @(negedge clk);
        chk("wd_63", stall_err_a, 0);
        @(negedge clk);
        chk("wd_64", stall_err_a, EXP_STALL);
        chk("wd_data", out_data_a, 8'h66);
        out_ready_a = 1'b1;
        wait_hs("wd_hs", d, l, c);
        chk("wd_xfer", d, 8'h66);
        repeat (2) @(negedge clk);
        chk("wd_sticky", stall_err_a, EXP_STALL);
        // READ_LATENCY=3 instance, BURST_LEN=1
        mem_b[wr_b] = 8'h7E;
        wr_b = wr_b + 1;
        drain_en_b = 1'b1;
        n = 0;
        while (!avalon_read_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) expired("b_read");
        tr = cyc;
        n = 0;
        while (!out_valid_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) expired("b_valid");
        tv = cyc;
        chk("b_latency", tv - tr, 4);
        chk("b_data", out_data_b, 8'h7E);
        chk("b_last", out_last_b, 1);
        @(negedge clk);
        chk("b_count", word_count_b, 1);
        chk("b_reads", reads_b, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
